// File: rtl/div.sv
// rtl/div.sv - sequential unsigned restoring divider, one quotient bit per clock
module div #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] a_bi,
    input  logic [WIDTH-1:0] b_bi,
    input  logic             start_i,
    output logic             busy_o,
    output logic [WIDTH-1:0] y_bo,
    output logic [WIDTH-1:0] r_bo,
    output logic             dz_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        WORK = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] dq;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   rem;
    logic [CW-1:0]    cnt;
    logic             dz_q;

    logic [WIDTH:0]   rem_sh;
    logic             q_bit;
    logic [WIDTH:0]   rem_nx;
    logic [WIDTH-1:0] dq_nx;

    // The partial remainder stays below the divisor, so the shifted value fits
    // in WIDTH+1 bits and a plain compare replaces the sign test of the trial.
    always_comb begin
        rem_sh = {rem[WIDTH-1:0], dq[WIDTH-1]};
        q_bit  = (rem_sh >= {1'b0, dvs});
        rem_nx = q_bit ? (rem_sh - {1'b0, dvs}) : rem_sh;
        dq_nx  = {dq[WIDTH-2:0], q_bit};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            dq     <= '0;
            dvs    <= '0;
            rem    <= '0;
            cnt    <= '0;
            dz_q   <= 1'b0;
            busy_o <= 1'b0;
            y_bo   <= '0;
            r_bo   <= '0;
            dz_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        dq     <= a_bi;
                        dvs    <= b_bi;
                        rem    <= '0;
                        cnt    <= '0;
                        dz_q   <= (b_bi == '0);
                        busy_o <= 1'b1;
                        state  <= WORK;
                    end
                end
                WORK: begin
                    dq  <= dq_nx;
                    rem <= rem_nx;
                    if (cnt == LAST_STEP) begin
                        cnt    <= '0;
                        y_bo   <= dq_nx;
                        r_bo   <= rem_nx[WIDTH-1:0];
                        dz_o   <= dz_q;
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
// tb/tb_div.sv - self-checking bench for div: vector table, corner sequences, random model
module tb_div;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a, b;
    logic         start;
    logic         busy;
    logic [W-1:0] y, r;
    logic         dz;

    int n_cmp = 0;
    int n_err = 0;

    div #(.WIDTH(W)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .a_bi   (a),
        .b_bi   (b),
        .start_i(start),
        .busy_o (busy),
        .y_bo   (y),
        .r_bo   (r),
        .dz_o   (dz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] y;
        logic [W-1:0] r;
        logic         dz;
    } vec_t;

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference: plain integer division, with the divide-by-zero convention
    // of quotient all ones and remainder equal to the dividend.
    task automatic model(input int va, input int vb, output int ey, output int er, output int edz);
        if (vb == 0) begin
            ey = (1 << W) - 1;
            er = va;
            edz = 1;
        end else begin
            ey = va / vb;
            er = va % vb;
            edz = 0;
        end
    endtask

    // Runs one division from IDLE. When disturb is set, start is pulsed and
    // the operands changed mid-operation; neither may affect the result.
    task automatic run_div(input string name, input int va, input int vb, input int ey,
                           input int er, input int edz, input bit disturb);
        int n;
        a = W'(va);
        b = W'(vb);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            if (disturb && n == 2) begin
                start = 1'b1;
                a = 8'd200;
                b = 8'd7;
            end else if (disturb && n == 3) begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        chk({name, " busy_len"}, n, W);
        chk({name, " y"}, y, ey);
        chk({name, " r"}, r, er);
        chk({name, " dz"}, dz, edz);
    endtask

    vec_t vecs[$];

    initial begin
        int ey, er, edz, n;
        int va, vb;

        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", busy, 0);
        chk("reset y", y, 0);
        chk("reset r", r, 0);
        chk("reset dz", dz, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        vecs.push_back('{8'd15, 8'd5, 8'd3, 8'd0, 1'b0});
        vecs.push_back('{8'd200, 8'd7, 8'd28, 8'd4, 1'b0});
        vecs.push_back('{8'd3, 8'd5, 8'd0, 8'd3, 1'b0});
        vecs.push_back('{8'd255, 8'd1, 8'd255, 8'd0, 1'b0});
        vecs.push_back('{8'd100, 8'd0, 8'hFF, 8'd100, 1'b1});
        vecs.push_back('{8'd9, 8'd3, 8'd3, 8'd0, 1'b0});
        vecs.push_back('{8'd255, 8'd255, 8'd1, 8'd0, 1'b0});
        vecs.push_back('{8'd0, 8'd0, 8'hFF, 8'd0, 1'b1});
        vecs.push_back('{8'd254, 8'd255, 8'd0, 8'd254, 1'b0});
        vecs.push_back('{8'd128, 8'd129, 8'd0, 8'd128, 1'b0});
        foreach (vecs[i])
            run_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].r,
                    vecs[i].dz, 1'b0);

        run_div("disturb", 15, 5, 3, 0, 0, 1'b1);

        // Start held high: 8 busy cycles, 1 idle, repeating; results change only at completion.
        run_div("pre_hold", 3, 5, 0, 3, 0, 1'b0);
        a = 8'd200;
        b = 8'd7;
        start = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 27; i++) begin
            chk($sformatf("hold busy[%0d]", i), busy, (i % 9) != 8);
            chk($sformatf("hold y[%0d]", i), y, (i < 8) ? 0 : 28);
            chk($sformatf("hold r[%0d]", i), r, (i < 8) ? 3 : 4);
            @(posedge clk); #1;
        end
        start = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        chk("hold drain", busy, 0);

        // Reset at the 4th busy cycle, with start still high on the reset edge.
        a = 8'd200;
        b = 8'd7;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst busy", busy, 1);
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        start = 1'b0;
        chk("rst busy", busy, 0);
        chk("rst y", y, 0);
        chk("rst r", r, 0);
        chk("rst dz", dz, 0);
        @(posedge clk); #1;
        chk("rst idle", busy, 0);
        run_div("after_rst", 50, 6, 8, 2, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            va = $urandom_range(0, 255);
            vb = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
            model(va, vb, ey, er, edz);
            run_div($sformatf("rand%0d %0d/%0d", i, va, vb), va, vb, ey, er, edz, 1'b0);
            if (vb != 0) chk($sformatf("rand%0d invariant", i), y * vb + r, va);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/div.md
# div

Sequential unsigned restoring divider, the inverse-operation companion to the `mul` multiplier in the arithmetic RTL set. It accepts a dividend and a divisor under the same `start_i`/`busy_o` handshake as `mul`. It produces one quotient bit per clock and returns the quotient and remainder. Downstream logic reads the outputs whenever `busy_o` is low.

## Interface

Parameters:
- `WIDTH`, default 8: operand, quotient and remainder width; the iteration counter is `$clog2(WIDTH)` bits.

Ports:
- `clk_i`, in, 1: clock; all state changes on the rising edge.
- `rst_i`, in, 1: reset; synchronous, active-high.
- `a_bi`, in, WIDTH: dividend, unsigned.
- `b_bi`, in, WIDTH: divisor, unsigned.
- `start_i`, in, 1: request; sampled only in IDLE.
- `busy_o`, out, 1: high while a division is in progress.
- `y_bo`, out, WIDTH: quotient of the last completed division.
- `r_bo`, out, WIDTH: remainder of the last completed division.
- `dz_o`, out, 1: divide-by-zero flag of the last completed division.

## Operation

- Two states: IDLE and WORK. The reset state is IDLE.
- Values after reset: `busy_o`=0, `y_bo`=0, `r_bo`=0, `dz_o`=0, counter=0, and all internal registers 0.
- In IDLE:
  - If `start_i`=1 at an edge, latch `a_bi` into the dividend/quotient shift register and `b_bi` into the divisor register.
  - Clear the partial remainder (WIDTH+1 bits), clear the counter, go to WORK, and set `busy_o`=1.
  - Set `dz_o` from (`b_bi`==0), but drive it to the output only at completion.
- In WORK, each edge performs one restoring step:
  - Shift {partial remainder, dividend} left by 1.
  - Compute trial = partial remainder − divisor (WIDTH+1 bits).
  - If the trial is non-negative, the partial remainder takes the trial value and the shifted-in quotient LSB is 1. Otherwise the partial remainder is kept and the LSB is 0.
  - Increment the counter.
- On the step where the counter equals WIDTH−1, i.e. the WIDTH-th step:
  - Register the quotient into `y_bo`, the low WIDTH bits of the remainder into `r_bo`, and the latched zero flag into `dz_o`.
  - Clear `busy_o` and return to IDLE.
- Operands are captured at start. Changes on `a_bi`/`b_bi` during WORK have no effect.
- `start_i` is ignored while in WORK, with no queuing.
- `y_bo`/`r_bo`/`dz_o` change only at completion or reset. Between completions they hold their previous values.
- Divisor 0: no special path. The restoring algorithm naturally yields quotient = all ones and remainder = dividend, and `dz_o`=1.
- Invariant for b≠0: `y_bo`*`b` + `r_bo` == `a`, with `r_bo` < `b`.

## Timing

- Start accepted at edge E0. `busy_o` is high from E0 through E0+WIDTH−1, i.e. exactly WIDTH cycles.
- Results and `busy_o`=0 appear after edge E0+WIDTH.
- With `start_i` held high, the next operation is accepted at edge E0+WIDTH+1. `busy_o` is low for exactly one cycle between operations, giving a throughput of one division per WIDTH+1 cycles.
- Reset during WORK: at the reset edge the operation is aborted. All outputs return to their reset values and the state is IDLE. `start_i` is not honoured at an edge where `rst_i`=1.
- Completion and `start_i` in the same cycle: the completion edge only finishes. The new start is sampled at the following edge.

## Test plan

- Reset, then start with a=15, b=5 → `busy_o` high for 8 cycles, then `y_bo`=3, `r_bo`=0, `dz_o`=0.
- Start with a=200, b=7 → `y_bo`=28, `r_bo`=4. Then a=3, b=5 → `y_bo`=0, `r_bo`=3. Then a=255, b=1 → `y_bo`=255, `r_bo`=0.
- Start with a=100, b=0 → `y_bo`=8'hFF, `r_bo`=100, `dz_o`=1. A following division 9/3 → `y_bo`=3, `dz_o`=0.
- Start with 15/5; during busy pulse `start_i` and change the operands to 200/7 → result is still 3 r 0 and busy length is unchanged at 8 cycles.
- `start_i` held high with fixed operands → busy pattern of 8 high, 1 low, repeating. Outputs update every 9 cycles.
- Assert `rst_i` at the 4th busy cycle → next cycle `busy_o`=0, `y_bo`=`r_bo`=0, `dz_o`=0. A subsequent 50/6 gives `y_bo`=8, `r_bo`=2.
